// File: rtl/even_count_sequencer_if.sv
// Command/status bundle for even_count_sequencer: move request handshake plus counter status.
interface even_count_sequencer_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STEPS_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_abort;
  logic [WIDTH-1:0]   Q;
  logic               Y;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               wrap;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_abort,
    input  cmd_ready, Q, Y, busy, done, aborted, wrap
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_abort,
    output cmd_ready, Q, Y, busy, done, aborted, wrap
  );
endinterface

// File: rtl/even_count_sequencer.sv
// Even up/down T-flip-flop counter (Q[0] tied low) with a command FSM that steps it N times.
// Optional macro SATURATE_EN: steps that would wrap are suppressed (Q clamps) and flagged on wrap.
module even_count_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STEPS_W = 4
) (
  input logic                   clk,
  input logic                   reset,
  even_count_sequencer_if.slave cmd
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:1]   q_q, q_d;
  logic               y_q, y_d;
  logic [STEPS_W-1:0] remaining_q, remaining_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               wrap_q, wrap_d;

  logic             step_en;
  logic             at_bound;
  logic [WIDTH-1:1] tog;

  // Toggle enables: a ripple of "all lower bits at the carry/borrow level";
  // the chain surviving past the MSB means the step would wrap.
  always_comb begin
    tog      = '0;
    at_bound = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog[i]   = at_bound;
      at_bound = at_bound & (y_q ? ~q_q[i] : q_q[i]);
    end
  end

  // Sequencer next-state and registered-output inputs.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    y_d         = y_q;
    remaining_d = remaining_q;
    aborted_d   = aborted_q;
    wrap_d      = 1'b0;
    step_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          y_d         = cmd.cmd_dir;
          remaining_d = cmd.cmd_steps;
          state_d     = (cmd.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cmd.cmd_abort) begin
          remaining_d = '0;
          aborted_d   = 1'b1;
          state_d     = DONE;
        end else begin
          step_en     = 1'b1;
          remaining_d = remaining_q - STEPS_W'(1);
          if (remaining_q == STEPS_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (step_en) begin
      wrap_d = at_bound;
`ifdef SATURATE_EN
      if (!at_bound) begin
        q_d = q_q ^ tog;
      end
`else
      q_d = q_q ^ tog;
`endif
    end

    // aborted is only meaningful alongside done
    if (state_d != DONE) begin
      aborted_d = 1'b0;
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      y_q         <= 1'b0;
      remaining_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      y_q         <= y_d;
      remaining_q <= remaining_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      wrap_q      <= wrap_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.Q         = {q_q, 1'b0};
  assign cmd.Y         = y_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.aborted   = aborted_q;
  assign cmd.wrap      = wrap_q;

endmodule

// File: tb/tb_even_count_sequencer.sv
// Self-checking bench for even_count_sequencer: directed scenarios plus randomized commands
// checked against an arithmetic model of the counter (closed-form Q after s steps).
module tb_even_count_sequencer;

  localparam int unsigned W    = 4;
  localparam int unsigned SW   = 4;
  localparam int          MOD  = 16;
  localparam int          MAXV = 14;

  logic clk = 1'b0;
  logic reset;

  even_count_sequencer_if #(.WIDTH(W), .STEPS_W(SW)) bus ();

  even_count_sequencer #(.WIDTH(W), .STEPS_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int model_cur = 0;
  int waited;

  logic [W-1:0] rq [0:19];
  logic rw [0:19];
  logic rb [0:19];
  logic rd [0:19];
  logic ra [0:19];
  logic rr [0:19];
  logic ry [0:19];

  // Counter value after s steps from start, straight from the modulo / clamp rule.
  function automatic int model_q(input int start, input bit dir, input int s);
    int v;
`ifdef SATURATE_EN
    if (dir) v = (start - 2 * s < 0) ? 0 : start - 2 * s;
    else     v = (start + 2 * s > MAXV) ? MAXV : start + 2 * s;
`else
    if (dir) v = (((start - 2 * s) % MOD) + MOD) % MOD;
    else     v = (start + 2 * s) % MOD;
`endif
    return v;
  endfunction

  function automatic bit at_boundary(input int v, input bit dir);
    return dir ? (v == 0) : (v == MAXV);
  endfunction

  task automatic record(input int c);
    rq[c] = bus.Q;
    rw[c] = bus.wrap;
    rb[c] = bus.busy;
    rd[c] = bus.done;
    ra[c] = bus.aborted;
    rr[c] = bus.cmd_ready;
    ry[c] = bus.Y;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_cur = 0;
  endtask

  // Issue one command (called at a negedge) and record outputs for cycles 0..steps+2
  // after the acceptance edge; abort_at = edge index (1..steps) to raise cmd_abort, 0 = none.
  task automatic drive_cmd(input bit dir, input int steps, input int abort_at);
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles, required 1", bus.cmd_ready, waited);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_steps = SW'(steps);
    bus.cmd_abort = 1'($urandom % 2);
    @(posedge clk);
    @(negedge clk);
    record(0);
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'($urandom % 2);
    bus.cmd_steps = SW'($urandom);
    bus.cmd_abort = 1'b0;
    for (int c = 1; c <= steps + 2; c++) begin
      if (c == abort_at) bus.cmd_abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_abort = 1'b0;
      record(c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.Q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b want 0000", bus.Q); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    checks++; if ({bus.Y, bus.busy, bus.done, bus.aborted, bus.wrap} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: Y/busy/done/aborted/wrap got %b want 00000",
                         {bus.Y, bus.busy, bus.done, bus.aborted, bus.wrap});
    end
    reset = 1'b0;
    model_cur = 0;
  endtask

  task automatic test_up3();
    logic [W-1:0] exp_q [0:5];
    exp_q = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd6, 4'd6};
    do_reset();
    drive_cmd(1'b0, 3, 0);
    for (int c = 0; c <= 5; c++) begin
      checks++; if (rq[c] !== exp_q[c]) begin errors++; $display("FAIL up3_q c=%0d: got %0d want %0d", c, rq[c], exp_q[c]); end
      checks++; if (rw[c] !== 1'b0) begin errors++; $display("FAIL up3_wrap c=%0d: got %b want 0", c, rw[c]); end
      checks++; if (rd[c] !== (c == 3)) begin errors++; $display("FAIL up3_done c=%0d: got %b want %b", c, rd[c], c == 3); end
      checks++; if (rr[c] !== (c >= 4)) begin errors++; $display("FAIL up3_ready c=%0d: got %b want %b", c, rr[c], c >= 4); end
    end
    checks++; if (ra[3] !== 1'b0) begin errors++; $display("FAIL up3_aborted: got %b want 0", ra[3]); end
    model_cur = 6;
  endtask

  task automatic test_down_wrap();
`ifdef SATURATE_EN
    int  e1 = 0, e2 = 0;
    bit  w2 = 1'b1;
`else
    int  e1 = 14, e2 = 12;
    bit  w2 = 1'b0;
`endif
    do_reset();
    drive_cmd(1'b1, 2, 0);
    checks++; if (rq[1] !== W'(e1)) begin errors++; $display("FAIL down_q1: got %0d want %0d", rq[1], e1); end
    checks++; if (rq[2] !== W'(e2)) begin errors++; $display("FAIL down_q2: got %0d want %0d", rq[2], e2); end
    checks++; if (rw[1] !== 1'b1) begin errors++; $display("FAIL down_wrap1: got %b want 1", rw[1]); end
    checks++; if (rw[2] !== w2) begin errors++; $display("FAIL down_wrap2: got %b want %b", rw[2], w2); end
    checks++; if (rw[3] !== 1'b0) begin errors++; $display("FAIL down_wrap3: got %b want 0", rw[3]); end
    for (int c = 0; c <= 2; c++) begin
      checks++; if (ry[c] !== 1'b1) begin errors++; $display("FAIL down_y c=%0d: got %b want 1", c, ry[c]); end
    end
    model_cur = e2;
  endtask

  task automatic test_zero_steps();
    int start = model_cur;
    drive_cmd(1'b0, 0, 0);
    for (int c = 0; c <= 2; c++) begin
      checks++; if (rq[c] !== W'(start)) begin errors++; $display("FAIL zero_q c=%0d: got %0d want %0d", c, rq[c], start); end
      checks++; if (rb[c] !== 1'b0) begin errors++; $display("FAIL zero_busy c=%0d: got %b want 0", c, rb[c]); end
      checks++; if (rd[c] !== (c == 0)) begin errors++; $display("FAIL zero_done c=%0d: got %b want %b", c, rd[c], c == 0); end
    end
    checks++; if (rr[1] !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", rr[1]); end
  endtask

  task automatic test_abort();
    do_reset();
    drive_cmd(1'b0, 5, 3);
    checks++; if (rq[3] !== 4'd4) begin errors++; $display("FAIL abort_q: got %0d want 4", rq[3]); end
    checks++; if (rq[5] !== 4'd4) begin errors++; $display("FAIL abort_qhold: got %0d want 4", rq[5]); end
    checks++; if (rd[3] !== 1'b1 || ra[3] !== 1'b1) begin
      errors++; $display("FAIL abort_done: done/aborted got %b%b want 11", rd[3], ra[3]);
    end
    checks++; if (rd[4] !== 1'b0 || ra[4] !== 1'b0) begin
      errors++; $display("FAIL abort_clear: done/aborted got %b%b want 00", rd[4], ra[4]);
    end
    checks++; if (rd[2] !== 1'b0) begin errors++; $display("FAIL abort_early_done: got %b want 0", rd[2]); end
    drive_cmd(1'b0, 1, 0);
    checks++; if (rq[1] !== 4'd6) begin errors++; $display("FAIL abort_next_q: got %0d want 6", rq[1]); end
    checks++; if (ra[1] !== 1'b0) begin errors++; $display("FAIL abort_next_aborted: got %b want 0", ra[1]); end
    model_cur = 6;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    do_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = SW'(6);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (bus.Q !== 4'd6 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: Q=%0d busy=%b want Q=6 busy=1", bus.Q, bus.busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.Q !== 4'd0) begin errors++; $display("FAIL midrun_q: got %0d want 0", bus.Q); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrun_state: ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.done !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrun_done: saw %0d done cycles want 0", seen); end
    checks++; if (bus.Q !== 4'd0) begin errors++; $display("FAIL midrun_qhold: got %0d want 0", bus.Q); end
    model_cur = 0;
  endtask

  task automatic test_back_to_back();
    drive_cmd(1'b0, 2, 0);
    checks++; if (rr[2] !== 1'b0 || rr[3] !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: c2/c3 got %b%b want 01", rr[2], rr[3]);
    end
    model_cur = model_q(model_cur, 1'b0, 2);
    drive_cmd(1'b1, 3, 0);
    checks++; if (waited != 0) begin errors++; $display("FAIL b2b_wait: waited %0d want 0", waited); end
    checks++; if (rq[3] !== W'(model_q(model_cur, 1'b1, 3))) begin
      errors++; $display("FAIL b2b_q: got %0d want %0d", rq[3], model_q(model_cur, 1'b1, 3));
    end
    model_cur = model_q(model_cur, 1'b1, 3);
  endtask

`ifdef SATURATE_EN
  task automatic test_saturate();
    do_reset();
    drive_cmd(1'b0, 6, 0);
    drive_cmd(1'b0, 3, 0);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (rq[c] !== 4'd14) begin errors++; $display("FAIL sat_q c=%0d: got %0d want 14", c, rq[c]); end
      checks++; if (rw[c] !== (c >= 2)) begin errors++; $display("FAIL sat_wrap c=%0d: got %b want %b", c, rw[c], c >= 2); end
    end
    checks++; if (rd[3] !== 1'b1) begin errors++; $display("FAIL sat_done: got %b want 1", rd[3]); end
    model_cur = 14;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      bit dir      = 1'($urandom % 2);
      int steps    = int'($urandom % 16);
      int abort_at = (steps > 0 && ($urandom % 4) == 0) ? 1 + int'($urandom % steps) : 0;
      int e_end    = (abort_at > 0) ? abort_at : steps;
      int taken    = (abort_at > 0) ? abort_at - 1 : steps;
      drive_cmd(dir, steps, abort_at);
      for (int c = 0; c <= steps + 2; c++) begin
        int s      = (c < taken) ? c : taken;
        int eq     = model_q(model_cur, dir, s);
        bit ew     = (c >= 1 && c <= taken) && at_boundary(model_q(model_cur, dir, c - 1), dir);
        bit ebusy  = (c < e_end);
        bit edone  = (c == e_end);
        bit eab    = (c == e_end) && (abort_at > 0);
        bit eready = (c > e_end);
        checks++; if (rq[c] !== W'(eq)) begin errors++; $display("FAIL rnd_q n=%0d c=%0d: got %0d want %0d", n, c, rq[c], eq); end
        checks++; if (rw[c] !== ew) begin errors++; $display("FAIL rnd_wrap n=%0d c=%0d: got %b want %b", n, c, rw[c], ew); end
        checks++; if (rb[c] !== ebusy) begin errors++; $display("FAIL rnd_busy n=%0d c=%0d: got %b want %b", n, c, rb[c], ebusy); end
        checks++; if (rd[c] !== edone) begin errors++; $display("FAIL rnd_done n=%0d c=%0d: got %b want %b", n, c, rd[c], edone); end
        checks++; if (ra[c] !== eab) begin errors++; $display("FAIL rnd_aborted n=%0d c=%0d: got %b want %b", n, c, ra[c], eab); end
        checks++; if (rr[c] !== eready) begin errors++; $display("FAIL rnd_ready n=%0d c=%0d: got %b want %b", n, c, rr[c], eready); end
        checks++; if (ry[c] !== dir) begin errors++; $display("FAIL rnd_y n=%0d c=%0d: got %b want %b", n, c, ry[c], dir); end
      end
      model_cur = model_q(model_cur, dir, taken);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_abort = 1'b0;
    test_reset();
    test_up3();
    test_down_wrap();
    test_zero_steps();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/even_count_sequencer.md
Name: even_count_sequencer

Overview:
Command-driven controller for the even up-down binary counter built from T flip-flops. It accepts a direction and step-count command through a valid/ready handshake. It drives the counter's direction input Y, steps the counter once per clock for the requested count, then reports completion. The block contains the T-flip-flop counter datapath and its FSM sequencer, so upstream logic issues moves rather than toggling Y directly.

Parameters:
WIDTH, 4, counter width in bits; Q[0] is hard-wired 0, so only even values are reachable (0 to 2^WIDTH-2).
STEPS_W, 4, width of the step-count field; a single command can request at most 2^STEPS_W-1 steps.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command; high only in IDLE.
cmd_dir  input  1  step direction; 0 = up (+2), 1 = down (-2); same encoding as Y.
cmd_steps  input  STEPS_W  number of counter steps to perform.
cmd_abort  input  1  stop the running command early.
Q  output  WIDTH  counter state.
Y  output  1  direction currently applied to the counter; latched cmd_dir.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when a command finishes.
aborted  output  1  high with done when the command ended via cmd_abort; 0 otherwise.
wrap  output  1  one-cycle pulse on any step that crosses the modulo boundary.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE, Q = 0, Y = 0, busy = 0, done = 0, aborted = 0, wrap = 0, remaining count = 0. This applies at any time, including mid-RUN; the command in progress is discarded with no done pulse.
- Counter datapath: T flip-flops on Q[WIDTH-1:1]; Q[0] is constant 0.
  - Up: T[1] = 1; T[i] = AND of Q[i-1:1].
  - Down: T[1] = 1; T[i] = AND of ~Q[i-1:1].
  - Toggles are applied only when the step is enabled.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready at an edge, latch cmd_dir into Y and cmd_steps into remaining. If cmd_steps = 0, go to DONE; otherwise go to RUN. cmd_abort is ignored in IDLE.
  - RUN: busy = 1, cmd_ready = 0. On each edge with cmd_abort = 0: step the counter by ±2 modulo 2^WIDTH and decrement remaining. When remaining = 1 at that edge, go to DONE.
  - RUN with cmd_abort = 1 at an edge: the step at that edge is suppressed, remaining is cleared, aborted is set, and the state goes to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. aborted holds its value during DONE and clears on leaving DONE. Q and Y hold.
- Latency: command accepted at edge k with N > 0 steps.
  - Q changes at edges k+1 through k+N.
  - done is high during the cycle after edge k+N.
  - cmd_ready rises after edge k+N+1.
  - For N = 0, done is high during the cycle after edge k.
- Throughput: one command per N+2 cycles; back-to-back commands are not pipelined.
- wrap is registered and high for the cycle after a step that moves Q from 2^WIDTH-2 to 0 (up) or from 0 to 2^WIDTH-2 (down).
- cmd_dir and cmd_steps are sampled only at acceptance; later changes have no effect on a running command.
- Q persists between commands; a new command continues from the current Q.

Optional Feature:
Macro SATURATE_EN.
- Defined: a step that would wrap is suppressed, so Q holds at 2^WIDTH-2 (up) or 0 (down). wrap pulses on each suppressed step to flag saturation. remaining still decrements, so done timing is unchanged.
- Not defined: the counter wraps modulo 2^WIDTH as described in Behaviour.

Test Plan:
- Reset, then command up, steps = 3 -> Q = 0010, 0100, 0110 on consecutive edges; done one cycle later; aborted = 0; wrap never asserted.
- From Q = 0000, command down, steps = 2 -> Q = 1110 then 1100; wrap pulses once, for the cycle after the first step; Y = 1 throughout.
- Command with steps = 0 -> done in the cycle after acceptance; Q unchanged; busy never asserted.
- Up, steps = 5 from 0000; assert cmd_abort after 2 steps -> Q stops at 0100; done = 1 with aborted = 1; next command accepted from Q = 0100.
- Assert reset mid-RUN (up, steps = 6, Q = 0110) -> Q = 0000, IDLE, cmd_ready = 1 immediately; no done pulse.
- SATURATE_EN defined: Q = 1100, up, steps = 3 -> Q = 1110, 1110, 1110; wrap pulses after the second and third steps; done after 3 steps.
